perf_event_counter_bank: RTL and testbench

- Synthesizable, parametrised performance-monitor block. It replaces the bench-only instruction and cache hit/request counting with hardware counters.
- It sits beside the processor core and samples one-bit event strobes each cycle: retire, I/D-cache request, I/D-cache hit, stalls.
- It provides a free-running cycle counter, freezes all counts when the core halts, and exposes a registered read port so software or the bench can dump the statistics.

---
 rtl/perf_event_counter_bank.sv | 116 +++++++++++
 tb/tb_perf_event_counter_bank.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_counter_bank.sv
// Performance-monitor counter bank: a free-running cycle counter plus one counter per event strobe.
// Counting stops while idle or halted, and a registered read port returns a counter value one cycle after the request.
module perf_event_counter_bank #(
    parameter int NUM_EVT = 6,
    parameter int CNT_W   = 32,
    parameter int SAT     = 1,
    parameter int SEL_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               halt,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic [NUM_EVT:0]   ovf,
    output logic               halted
);

    localparam int NCNT = NUM_EVT + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             counting;
    logic [NCNT-1:0]  inc;
    logic [CNT_W-1:0] cnt [NCNT];
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_next = state;
        counting   = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state_next = RUN;
                end
                RUN: begin
                    if (!en) begin
                        state_next = IDLE;
                    end else begin
                        counting = 1'b1;
                        if (halt) state_next = HALTED;
                    end
                end
                HALTED:  state_next = HALTED;
                default: state_next = IDLE;
            endcase
        end
    end

    // Bit 0 is the cycle tick; the event strobes occupy the upper bits.
    assign inc    = {evt, 1'b1} & {NCNT{counting}};
    assign halted = (state == HALTED);

    // NOTE: the counters are individual flops rather than a RAM, so resetting the whole array is cheap and required.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                if (inc[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
                        if (SAT == 0) cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Selects above NUM_EVT match no counter and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
        end
    end

    // The read samples the pre-edge counter contents, so a simultaneous clear or increment is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Self-checking bench: three counter banks (32-bit saturating, 8-bit saturating, 8-bit wrapping) share one stimulus.
// A reference model keeps exact event totals and derives each bank's expected view from them.
module tb_perf_event_counter_bank;

    localparam int NUM_EVT = 6;
    localparam int SEL_W   = 3;

    typedef enum {M_IDLE, M_RUN, M_HALTED} mode_t;

    logic               clk = 1'b0;
    logic               rst, en, clr, halt, rd_req;
    logic [NUM_EVT-1:0] evt;
    logic [SEL_W-1:0]   rd_sel;

    logic [31:0]      rd_data_a;
    logic [7:0]       rd_data_s, rd_data_w;
    logic             rd_valid_a, rd_valid_s, rd_valid_w;
    logic [NUM_EVT:0] ovf_a, ovf_s, ovf_w;
    logic             halted_a, halted_s, halted_w;

    perf_event_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(32), .SAT(1), .SEL_W(SEL_W)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .ovf(ovf_a), .halted(halted_a));

    perf_event_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(8), .SAT(1), .SEL_W(SEL_W)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .ovf(ovf_s), .halted(halted_s));

    perf_event_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(8), .SAT(0), .SEL_W(SEL_W)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_valid(rd_valid_w),
        .ovf(ovf_w), .halted(halted_w));

    always #5 clk = ~clk;

    // Reference model: exact totals per counter, plus the expected read-port view.
    longint unsigned tot [NUM_EVT+1];
    mode_t           mode;
    logic            e_valid;
    logic [63:0]     e_rd_a, e_rd_s, e_rd_w;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic model_reset();
        foreach (tot[i]) tot[i] = 0;
        mode    = M_IDLE;
        e_valid = 1'b0;
        e_rd_a  = '0;
        e_rd_s  = '0;
        e_rd_w  = '0;
    endtask

    task automatic check_all(input string tag);
        logic [NUM_EVT:0] eo_a, eo_8;
        for (int i = 0; i <= NUM_EVT; i++) begin
            eo_a[i] = (tot[i] > 64'hFFFF_FFFF);
            eo_8[i] = (tot[i] > 255);
        end
        check({tag, "_valid_a"}, 64'(rd_valid_a), 64'(e_valid));
        check({tag, "_valid_s"}, 64'(rd_valid_s), 64'(e_valid));
        check({tag, "_valid_w"}, 64'(rd_valid_w), 64'(e_valid));
        check({tag, "_data_a"}, 64'(rd_data_a), e_rd_a);
        check({tag, "_data_s"}, 64'(rd_data_s), e_rd_s);
        check({tag, "_data_w"}, 64'(rd_data_w), e_rd_w);
        check({tag, "_ovf_a"}, 64'(ovf_a), 64'(eo_a));
        check({tag, "_ovf_s"}, 64'(ovf_s), 64'(eo_8));
        check({tag, "_ovf_w"}, 64'(ovf_w), 64'(eo_8));
        check({tag, "_halted_a"}, 64'(halted_a), 64'(mode == M_HALTED));
        check({tag, "_halted_s"}, 64'(halted_s), 64'(mode == M_HALTED));
        check({tag, "_halted_w"}, 64'(halted_w), 64'(mode == M_HALTED));
    endtask

    // One clock edge: advance the model with the current inputs, then compare 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        e_valid = rd_req;
        if (rd_req) begin
            if (int'(rd_sel) <= NUM_EVT) begin
                e_rd_a = 64'(tot[rd_sel] % 64'h1_0000_0000);
                e_rd_s = (tot[rd_sel] > 255) ? 64'd255 : 64'(tot[rd_sel]);
                e_rd_w = 64'(tot[rd_sel] % 256);
            end else begin
                e_rd_a = '0;
                e_rd_s = '0;
                e_rd_w = '0;
            end
        end
        if (clr) begin
            foreach (tot[i]) tot[i] = 0;
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: if (en) mode = M_RUN;
                M_RUN: begin
                    if (!en) begin
                        mode = M_IDLE;
                    end else begin
                        tot[0]++;
                        for (int i = 0; i < NUM_EVT; i++) tot[i+1] += 64'(evt[i]);
                        if (halt) mode = M_HALTED;
                    end
                end
                default: ;
            endcase
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; halt = 1'b0; evt = '0; rd_req = 1'b0; rd_sel = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clr = 1'b1;
        step("clr");
        clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        en  = 1'b1;
        #12;
        check_all("reset");
        rst = 1'b0;

        // Ten counted RUN cycles after the IDLE->RUN transition edge.
        evt = 6'b000001;
        repeat (11) step("t1_run");
        en = 1'b0; evt = '0; rd_req = 1'b1; rd_sel = 3'd0;
        step("t1_rd0");
        check("t1_cycle_is_10", 64'(rd_data_a), 64'd10);
        rd_sel = 3'd1;
        step("t1_rd1");
        check("t1_evt0_is_10", 64'(rd_data_a), 64'd10);
        check("t1_no_ovf", 64'(ovf_a), 64'd0);
        rd_req = 1'b0;

        // Halt on the third evt[2] cycle's successor; counts freeze afterwards.
        do_clear();
        en = 1'b1;
        step("t2_enter");
        evt = 6'b000100;
        repeat (3) step("t2_evt");
        halt = 1'b1;
        step("t2_halt");
        halt = 1'b0;
        check("t2_halted", 64'(halted_a), 64'd1);
        for (int k = 0; k < 12; k++) begin
            en   = 1'($urandom);
            evt  = 6'($urandom);
            halt = 1'($urandom);
            step("t2_frozen");
        end
        evt = '0; halt = 1'b0; rd_req = 1'b1; rd_sel = 3'd3;
        step("t2_rd3");
        check("t2_evt2_is_4", 64'(rd_data_a), 64'd4);
        rd_req = 1'b0;

        // 300 events into the 8-bit banks: saturate vs wrap.
        do_clear();
        en = 1'b1; evt = 6'b000001;
        repeat (301) step("t3_run");
        en = 1'b0; evt = '0; rd_req = 1'b1; rd_sel = 3'd1;
        step("t3_rd1");
        check("t3_sat_255", 64'(rd_data_s), 64'd255);
        check("t3_wrap_44", 64'(rd_data_w), 64'd44);
        check("t3_ovf_s1", 64'(ovf_s[1]), 64'd1);
        check("t3_ovf_w1", 64'(ovf_w[1]), 64'd1);
        rd_req = 1'b0;

        // Clear and read in the same cycle returns the pre-clear value.
        do_clear();
        en = 1'b1;
        step("t4_enter");
        evt = 6'b000010;
        repeat (7) step("t4_evt");
        en = 1'b0; evt = '0;
        step("t4_idle");
        clr = 1'b1; rd_req = 1'b1; rd_sel = 3'd2;
        step("t4_clr_rd");
        check("t4_preclear_7", 64'(rd_data_a), 64'd7);
        clr = 1'b0;
        step("t4_rd_again");
        check("t4_cleared_0", 64'(rd_data_a), 64'd0);
        check("t4_ovf_0", 64'(ovf_a), 64'd0);
        rd_req = 1'b0;

        // Back-to-back reads, then asynchronous reset in the middle of the stream.
        en = 1'b1; evt = 6'b111111;
        repeat (5) step("t5_run");
        rd_req = 1'b1;
        rd_sel = 3'd0; step("t5_b2b0");
        rd_sel = 3'd1; step("t5_b2b1");
        rd_sel = 3'd7; step("t5_b2b7");
        check("t5_sel7_zero", 64'(rd_data_a), 64'd0);
        check("t5_sel7_valid", 64'(rd_valid_a), 64'd1);
        rd_sel = 3'd2;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t5_async_rst");
        #1;
        rst = 1'b0;
        en = 1'b0; evt = '0;
        for (int s = 0; s <= NUM_EVT; s++) begin
            rd_sel = 3'(s);
            step("t5_rd_zero");
        end
        rd_req = 1'b0;

        // en toggling under a continuous evt[5] stream: 4 + 3 counted RUN cycles.
        do_clear();
        evt = 6'b100000;
        en = 1'b1; repeat (5) step("t6_en1");
        en = 1'b0; repeat (3) step("t6_en0");
        en = 1'b1; repeat (4) step("t6_en1b");
        en = 1'b0; rd_req = 1'b1; rd_sel = 3'd6;
        step("t6_rd6");
        check("t6_evt5_is_7", 64'(rd_data_a), 64'd7);
        rd_req = 1'b0; evt = '0;

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            en     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 99) == 0);
            halt   = ($urandom_range(0, 59) == 0);
            evt    = 6'($urandom);
            rd_req = 1'($urandom);
            rd_sel = 3'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
